// File: rtl/data_mem_port.sv
// Data-side memory port: multi-cycle word RAM with byte-lane writes and a busy/ready handshake.
// Optional macro DMEM_PORT_RANGE_CHECK_EN enables out-of-range detection and the AddrError pulse.
module data_mem_port #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] DataOut,
    output logic        MemReady,
    output logic        AddrError
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             data_q;
    logic [3:0]              we_q;
    logic                    is_wr_q;
    logic                    request;
    logic [31:0]             mem [2**ADDR_WIDTH];

    assign request = ReadEnable | (|WriteEnable);

`ifdef DMEM_PORT_RANGE_CHECK_EN
    logic err_q;
    logic range_err;
    logic unused_addr_bits;

    assign range_err        = |Address[31:ADDR_WIDTH+2];
    assign unused_addr_bits = ^Address[1:0];
    assign AddrError        = (state_q == S_ACCESS) & err_q;
`else
    logic unused_addr_bits;

    // Upper address bits alias onto the array when range checking is off.
    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
    assign AddrError        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (request) state_d = S_WAIT;
            S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            MemReady <= 1'b0;
            DataOut  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        addr_q   <= Address[ADDR_WIDTH+1:2];
                        data_q   <= DataIn;
                        we_q     <= WriteEnable;
                        is_wr_q  <= |WriteEnable;
                        cnt_q    <= 4'(WAIT_STATES);
                        MemReady <= 1'b1;
`ifdef DMEM_PORT_RANGE_CHECK_EN
                        err_q    <= range_err;
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                S_ACCESS: begin
                    MemReady <= 1'b0;
                    // A request with both strobes and ReadEnable is a write; DataOut holds.
                    if (!is_wr_q) begin
`ifdef DMEM_PORT_RANGE_CHECK_EN
                        DataOut <= err_q ? 32'hDEAD_BEEF : mem[addr_q];
`else
                        DataOut <= mem[addr_q];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is never reset; a reset during the access discards the pending write.
    always_ff @(posedge clk) begin
`ifdef DMEM_PORT_RANGE_CHECK_EN
        if (!rst && state_q == S_ACCESS && is_wr_q && !err_q) begin
`else
        if (!rst && state_q == S_ACCESS && is_wr_q) begin
`endif
            for (int unsigned i = 0; i < 4; i++) begin
                if (we_q[i]) mem[addr_q][i*8 +: 8] <= data_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: vector table plus scoreboard, with hand-written
// sequences for reset mid-access, inputs ignored while busy, and the range-check option.
module tb_data_mem_port;

    localparam int unsigned WS = 2;
`ifdef DMEM_PORT_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [3:0]  WriteEnable;
    logic        ReadEnable;
    logic [31:0] DataOut;
    logic        MemReady;
    logic        AddrError;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    data_mem_port #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .DataIn      (DataIn),
        .WriteEnable (WriteEnable),
        .ReadEnable  (ReadEnable),
        .DataOut     (DataOut),
        .MemReady    (MemReady),
        .AddrError   (AddrError)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic        re;
        logic [31:0] exp_dout;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        int unsigned busy;
        int unsigned aerr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Address     = '0;
        DataIn      = '0;
        WriteEnable = '0;
        ReadEnable  = 1'b0;
    endtask

    // One request pulse; optionally a stray write to 0x10 is driven while busy.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                           input logic re, input logic [31:0] exp_d, input int unsigned exp_ae,
                           input string name, input bit noise);
        exp_t e;
        exp_t got;
        int unsigned busy;
        int unsigned ae;
        bit done;
        @(negedge clk);
        Address = a; DataIn = d; WriteEnable = we; ReadEnable = re;
        e.dout = exp_d; e.busy = WS + 2; e.aerr = exp_ae;
        sb.push_back(e);
        @(posedge clk);
        #1 clear_inputs();
        busy = 0; ae = 0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (noise) clear_inputs();
            if (AddrError) ae++;
            if (MemReady) begin
                busy++;
                if (noise && busy == 1) begin
                    Address = 32'h10; DataIn = 32'h0; WriteEnable = 4'hF; ReadEnable = 1'b1;
                end
            end else if (busy != 0) begin
                done = 1'b1;
            end
        end
        got = sb.pop_front();
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: busy=%0d never returned ready", name, busy);
        end else begin
            check({name, " busy"}, busy, got.busy);
            check({name, " dout"}, DataOut, got.dout);
            check({name, " aerr"}, ae, got.aerr);
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h10, 32'h1234_5678, 4'hF,    1'b0, 32'h0};
        vecs[1] = '{32'h10, 32'h0,         4'h0,    1'b1, 32'h1234_5678};
        vecs[2] = '{32'h20, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h1234_5678};
        vecs[3] = '{32'h20, 32'hAAAA_AAAA, 4'b0100, 1'b0, 32'h1234_5678};
        vecs[4] = '{32'h20, 32'h0,         4'h0,    1'b1, 32'hFFAA_FFFF};
        vecs[5] = '{32'h30, 32'hCAFE_F00D, 4'hF,    1'b1, 32'hFFAA_FFFF};
        vecs[6] = '{32'h30, 32'h0,         4'h0,    1'b1, 32'hCAFE_F00D};
        vecs[7] = '{32'h13, 32'h0,         4'h0,    1'b1, 32'h1234_5678};
        vecs[8] = '{32'h0,  32'h0BAD_F00D, 4'hF,    1'b0, 32'h1234_5678};

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dout", DataOut, 32'h0);
        check("reset ready", {31'b0, MemReady}, 32'h0);
        check("reset aerr", {31'b0, AddrError}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].re, vecs[i].exp_dout,
                    0, $sformatf("vec%0d", i), 1'b0);

        // Stray write to 0x10 while busy must be ignored.
        run_txn(32'h40, 32'h5555_5555, 4'hF, 1'b0, 32'h1234_5678, 0, "busy_ign_wr", 1'b1);
        run_txn(32'h10, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 0, "busy_ign_rd", 1'b0);

        // Reset during WAIT of a write to 0x20: write must be dropped.
        @(negedge clk);
        Address = 32'h20; DataIn = 32'h0; WriteEnable = 4'hF;
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("midrst busy", {31'b0, MemReady}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", {31'b0, MemReady}, 32'h0);
        check("midrst dout", DataOut, 32'h0);
        repeat (WS + 3) @(negedge clk);
        check("midrst idle", {31'b0, MemReady}, 32'h0);
        run_txn(32'h20, 32'h0, 4'h0, 1'b1, 32'hFFAA_FFFF, 0, "midrst_rd", 1'b0);

        // Out-of-range: error pulse and DEADBEEF with the option, aliasing to word 0 without.
        run_txn(32'h8000_0000, 32'h0, 4'h0, 1'b1, RC ? 32'hDEAD_BEEF : 32'h0BAD_F00D,
                RC ? 1 : 0, "range_rd", 1'b0);
        run_txn(32'h8000_0000, 32'h1111_1111, 4'hF, 1'b0, RC ? 32'hDEAD_BEEF : 32'h0BAD_F00D,
                RC ? 1 : 0, "range_wr", 1'b0);
        run_txn(32'h0, 32'h0, 4'h0, 1'b1, RC ? 32'h0BAD_F00D : 32'h1111_1111,
                0, "range_alias", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
